// File: rtl/me1_mem_stage.sv
// rtl/me1_mem_stage.sv - ME1 memory stage: data-memory access, load alignment, branch resolve, WB1 registers
module me1_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        r_me1_valid_Q,
    input  logic [31:0] r_me1_pc_Q,
    input  logic [31:0] r_me1_alu_Q,
    input  logic [31:0] r_me1_bradd_Q,
    input  logic [31:0] r_me1_wtdat_Q,
    input  logic [3:0]  r_me1_memop_Q,
    input  logic [2:0]  r_me1_branchop_Q,
    input  logic        r_me1_zero_Q,
    input  logic [4:0]  r_me1_rd_Q,
    input  logic        r_me1_regwrite_Q,
    input  logic [1:0]  r_me1_rfwt_sel_Q,
    input  logic        r_me1_order_Q,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err,
    output logic        me1_stall,
    output logic        me1_redirect,
    output logic [31:0] me1_target,
    output logic        wb1_valid,
    output logic [4:0]  wb1_rd,
    output logic        wb1_regwrite,
    output logic [31:0] wb1_result,
    output logic [31:0] wb1_pc,
    output logic        wb1_order,
    output logic        wb1_exc,
    output logic [1:0]  wb1_cause
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t     state_q;
    logic [7:0] tmo_cnt_q;

    logic        is_load, is_store, sext, aligned;
    logic [1:0]  sz;
    logic [1:0]  byte_off;
    logic        memacc, misalign, in_resp, timeout, resp_done, stall_raw;
    logic        bus_err, exc, taken, complete;
    logic [1:0]  cause;
    logic [31:0] lane, load_data, result;

    assign byte_off = r_me1_alu_Q[1:0];

    // sz: 0 byte, 1 half, 2 word
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz       = 2'd0;
        sext     = 1'b0;
        case (r_me1_memop_Q)
            4'h1: begin is_store = 1'b1; sz = 2'd0; end
            4'h2: begin is_store = 1'b1; sz = 2'd1; end
            4'h3: begin is_store = 1'b1; sz = 2'd2; end
            4'h8: begin is_load = 1'b1; sz = 2'd0; sext = 1'b1; end
            4'h9: begin is_load = 1'b1; sz = 2'd1; sext = 1'b1; end
            4'hA: begin is_load = 1'b1; sz = 2'd2; end
            4'hC: begin is_load = 1'b1; sz = 2'd0; end
            4'hD: begin is_load = 1'b1; sz = 2'd1; end
            default: ;
        endcase
    end

    always_comb begin
        case (sz)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~byte_off[0];
            default: aligned = (byte_off == 2'b00);
        endcase
    end

    assign memacc   = r_me1_valid_Q & (is_load | is_store) & aligned;
    assign misalign = r_me1_valid_Q & (is_load | is_store) & ~aligned;

    assign in_resp   = (state_q == S_RESP);
    assign timeout   = in_resp & ~dmem_rvalid & (tmo_cnt_q == TMO_LIMIT);
    assign resp_done = in_resp & (dmem_rvalid | timeout);
    assign stall_raw = memacc & ~resp_done;
    assign bus_err   = in_resp & dmem_rvalid & dmem_err;

    assign dmem_req   = RST & memacc & ~in_resp;
    assign dmem_we    = is_store;
    assign dmem_addr  = {r_me1_alu_Q[31:2], 2'b00};
    assign me1_stall  = RST & stall_raw;

    always_comb begin
        case (sz)
            2'd0: begin
                dmem_be    = 4'b0001 << byte_off;
                dmem_wdata = {4{r_me1_wtdat_Q[7:0]}};
            end
            2'd1: begin
                dmem_be    = 4'b0011 << byte_off;
                dmem_wdata = {2{r_me1_wtdat_Q[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = r_me1_wtdat_Q;
            end
        endcase
    end

    assign lane = dmem_rdata >> {byte_off, 3'b000};

    always_comb begin
        case (sz)
            2'd0:    load_data = {{24{sext & lane[7]}}, lane[7:0]};
            2'd1:    load_data = {{16{sext & lane[15]}}, lane[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        case (r_me1_branchop_Q)
            3'd1:    taken = r_me1_zero_Q;
            3'd2:    taken = ~r_me1_zero_Q;
            3'd3:    taken = 1'b1;
            3'd4:    taken = r_me1_alu_Q[0];
            3'd5:    taken = ~r_me1_alu_Q[0];
            default: taken = 1'b0;
        endcase
    end

    // Misalignment outranks bus error, which outranks timeout
    assign exc   = misalign | bus_err | timeout;
    assign cause = misalign ? 2'd1 : bus_err ? 2'd2 : timeout ? 2'd3 : 2'd0;

    assign me1_redirect = RST & r_me1_valid_Q & taken & ~stall_raw & ~exc;
    assign me1_target   = r_me1_bradd_Q;

    always_comb begin
        case (r_me1_rfwt_sel_Q)
            2'd1:    result = load_data;
            2'd2:    result = r_me1_pc_Q + 32'd4;
            default: result = r_me1_alu_Q;
        endcase
    end

    assign complete = r_me1_valid_Q & ~stall_raw;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            tmo_cnt_q    <= '0;
            wb1_valid    <= 1'b0;
            wb1_rd       <= '0;
            wb1_regwrite <= 1'b0;
            wb1_result   <= '0;
            wb1_pc       <= '0;
            wb1_order    <= 1'b0;
            wb1_exc      <= 1'b0;
            wb1_cause    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tmo_cnt_q <= '0;
                    if (memacc) state_q <= dmem_gnt ? S_RESP : S_REQ;
                end
                S_REQ: begin
                    if (dmem_gnt) state_q <= S_RESP;
                end
                S_RESP: begin
                    if (resp_done) begin
                        state_q   <= S_IDLE;
                        tmo_cnt_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // A stalled cycle inserts a bubble; payload holds
            wb1_valid <= complete;
            if (complete) begin
                wb1_rd       <= r_me1_rd_Q;
                wb1_regwrite <= r_me1_regwrite_Q & ~exc;
                wb1_result   <= result;
                wb1_pc       <= r_me1_pc_Q;
                wb1_order    <= r_me1_order_Q;
                wb1_exc      <= exc;
                wb1_cause    <= cause;
            end
        end
    end

endmodule

// File: tb/tb_me1_mem_stage.sv
// tb/tb_me1_mem_stage.sv - self-checking bench for me1_mem_stage with a transaction-level reference model
module tb_me1_mem_stage;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        r_me1_valid_Q;
    logic [31:0] r_me1_pc_Q, r_me1_alu_Q, r_me1_bradd_Q, r_me1_wtdat_Q;
    logic [3:0]  r_me1_memop_Q;
    logic [2:0]  r_me1_branchop_Q;
    logic        r_me1_zero_Q;
    logic [4:0]  r_me1_rd_Q;
    logic        r_me1_regwrite_Q;
    logic [1:0]  r_me1_rfwt_sel_Q;
    logic        r_me1_order_Q;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0] dmem_rdata;
    logic        me1_stall, me1_redirect;
    logic [31:0] me1_target;
    logic        wb1_valid, wb1_regwrite, wb1_order, wb1_exc;
    logic [4:0]  wb1_rd;
    logic [31:0] wb1_result, wb1_pc;
    logic [1:0]  wb1_cause;

    always #5 CLK = ~CLK;

    me1_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .r_me1_valid_Q(r_me1_valid_Q), .r_me1_pc_Q(r_me1_pc_Q), .r_me1_alu_Q(r_me1_alu_Q),
        .r_me1_bradd_Q(r_me1_bradd_Q), .r_me1_wtdat_Q(r_me1_wtdat_Q), .r_me1_memop_Q(r_me1_memop_Q),
        .r_me1_branchop_Q(r_me1_branchop_Q), .r_me1_zero_Q(r_me1_zero_Q), .r_me1_rd_Q(r_me1_rd_Q),
        .r_me1_regwrite_Q(r_me1_regwrite_Q), .r_me1_rfwt_sel_Q(r_me1_rfwt_sel_Q), .r_me1_order_Q(r_me1_order_Q),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .me1_stall(me1_stall), .me1_redirect(me1_redirect), .me1_target(me1_target),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_regwrite(wb1_regwrite), .wb1_result(wb1_result),
        .wb1_pc(wb1_pc), .wb1_order(wb1_order), .wb1_exc(wb1_exc), .wb1_cause(wb1_cause)
    );

    int errors = 0;
    int checks = 0;
    int req_cnt = 0;
    int stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [3:0] op);
        case (op)
            4'h1, 4'h8, 4'hC: return 1;
            4'h2, 4'h9, 4'hD: return 2;
            4'h3, 4'hA:       return 4;
            default:          return 0;
        endcase
    endfunction

    // Reference model: phase 0 free, 1 awaiting grant, 2 awaiting response
    int          m_phase = 0;
    int          m_waited = 0;
    bit          have_exp = 0;
    logic        e_valid, e_rw, e_order, e_exc;
    logic [4:0]  e_rd;
    logic [31:0] e_res, e_pc;
    logic [1:0]  e_cause;
    bit          e_res_dc;

    always @(negedge CLK) begin : model_chk
        int nb, off;
        bit acc, mis, in_resp, tmo, done, x_stall, x_req, taken, exc, redir, berr, sgn;
        logic [1:0]  cause;
        logic [31:0] v;

        if (have_exp) begin
            chk("wb1_valid", wb1_valid, e_valid);
            chk("wb1_rd", wb1_rd, e_rd);
            chk("wb1_regwrite", wb1_regwrite, e_rw);
            chk("wb1_pc", wb1_pc, e_pc);
            chk("wb1_order", wb1_order, e_order);
            chk("wb1_exc", wb1_exc, e_exc);
            chk("wb1_cause", wb1_cause, e_cause);
            if (!e_res_dc) chk("wb1_result", wb1_result, e_res);
        end

        nb  = nbytes(r_me1_memop_Q);
        off = int'(r_me1_alu_Q[1:0]);
        acc = 0;
        mis = 0;
        if (r_me1_valid_Q && nb != 0) begin
            if (off % nb == 0) acc = 1;
            else mis = 1;
        end
        in_resp = (m_phase == 2);
        tmo     = in_resp && !dmem_rvalid && (m_waited == TMO);
        done    = in_resp && (dmem_rvalid || tmo);
        berr    = in_resp && dmem_rvalid && dmem_err;
        x_stall = RST && acc && !done;
        x_req   = RST && acc && !in_resp;
        exc     = mis || berr || tmo;
        cause   = mis ? 2'd1 : berr ? 2'd2 : tmo ? 2'd3 : 2'd0;
        case (r_me1_branchop_Q)
            3'd1: taken = r_me1_zero_Q;
            3'd2: taken = !r_me1_zero_Q;
            3'd3: taken = 1;
            3'd4: taken = r_me1_alu_Q[0];
            3'd5: taken = !r_me1_alu_Q[0];
            default: taken = 0;
        endcase
        redir = RST && r_me1_valid_Q && taken && !x_stall && !exc;

        chk("me1_stall", me1_stall, x_stall);
        chk("dmem_req", dmem_req, x_req);
        chk("me1_redirect", me1_redirect, redir);
        chk("me1_target", me1_target, r_me1_bradd_Q);
        if (x_req) begin
            chk("dmem_addr", dmem_addr, r_me1_alu_Q & 32'hFFFF_FFFC);
            chk("dmem_we", dmem_we, r_me1_memop_Q inside {4'h1, 4'h2, 4'h3});
            chk("dmem_be", dmem_be, 32'(((1 << nb) - 1) << off) & 32'hF);
            v = (nb == 1) ? r_me1_wtdat_Q[7:0] * 32'h0101_0101 :
                (nb == 2) ? r_me1_wtdat_Q[15:0] * 32'h0001_0001 : r_me1_wtdat_Q;
            chk("dmem_wdata", dmem_wdata, v);
        end
        if (dmem_req === 1'b1) req_cnt++;
        if (me1_stall === 1'b1) stall_cnt++;

        if (!RST) begin
            m_phase = 0; m_waited = 0;
            e_valid = 0; e_rd = 0; e_rw = 0; e_res = 0; e_pc = 0; e_order = 0; e_exc = 0; e_cause = 0;
            e_res_dc = 0;
        end else begin
            if (in_resp) begin
                if (done) begin m_phase = 0; m_waited = 0; end
                else m_waited++;
            end else if (acc) begin
                m_phase = dmem_gnt ? 2 : 1;
            end
            e_valid = r_me1_valid_Q && !x_stall;
            if (e_valid) begin
                sgn = r_me1_memop_Q inside {4'h8, 4'h9};
                v = dmem_rdata >> (off * 8);
                if (nb == 1) begin
                    v = v & 32'hFF;
                    if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
                end else if (nb == 2) begin
                    v = v & 32'hFFFF;
                    if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
                end
                case (r_me1_rfwt_sel_Q)
                    2'd1: e_res = v;
                    2'd2: e_res = r_me1_pc_Q + 4;
                    default: e_res = r_me1_alu_Q;
                endcase
                e_res_dc = exc;
                e_rd     = r_me1_rd_Q;
                e_rw     = r_me1_regwrite_Q && !exc;
                e_pc     = r_me1_pc_Q;
                e_order  = r_me1_order_Q;
                e_exc    = exc;
                e_cause  = cause;
            end
        end
        have_exp = 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] memop, input logic [2:0] bop, input logic [31:0] alu,
                             input logic [31:0] wtdat, input logic [1:0] sel, input logic rw,
                             input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] bradd,
                             input logic zero);
        r_me1_valid_Q    = 1;
        r_me1_memop_Q    = memop;
        r_me1_branchop_Q = bop;
        r_me1_alu_Q      = alu;
        r_me1_wtdat_Q    = wtdat;
        r_me1_rfwt_sel_Q = sel;
        r_me1_regwrite_Q = rw;
        r_me1_rd_Q       = rd;
        r_me1_pc_Q       = pc;
        r_me1_bradd_Q    = bradd;
        r_me1_zero_Q     = zero;
        r_me1_order_Q    = ~r_me1_order_Q;
        req_cnt   = 0;
        stall_cnt = 0;
    endtask

    task automatic bubble();
        r_me1_valid_Q    = 0;
        r_me1_memop_Q    = 0;
        r_me1_branchop_Q = 0;
    endtask

    // Memory responder: grant after gd cycles, respond rd_dly cycles after grant
    task automatic mem_instr(input int gd, input int rd_dly, input logic [31:0] rdata,
                             input logic err, input bit resp);
        for (int n = 0; n < gd; n++) begin dmem_gnt = 0; tick(); end
        dmem_gnt = 1;
        tick();
        dmem_gnt = 0;
        for (int n = 0; n < rd_dly; n++) tick();
        if (resp) begin
            dmem_rvalid = 1; dmem_rdata = rdata; dmem_err = err;
            tick();
            dmem_rvalid = 0; dmem_err = 0;
        end
    endtask

    initial begin
        RST = 0;
        r_me1_valid_Q = 0; r_me1_pc_Q = 0; r_me1_alu_Q = 0; r_me1_bradd_Q = 0; r_me1_wtdat_Q = 0;
        r_me1_memop_Q = 0; r_me1_branchop_Q = 0; r_me1_zero_Q = 0; r_me1_rd_Q = 0;
        r_me1_regwrite_Q = 0; r_me1_rfwt_sel_Q = 0; r_me1_order_Q = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0; dmem_err = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_wb1_valid", wb1_valid, 0);
        chk("rst_wb1_result", wb1_result, 0);
        chk("rst_req", dmem_req, 0);
        RST = 1;
        tick();

        set_instr(4'h0, 3'd0, 32'h10, 0, 2'd0, 1, 5'd5, 32'h100, 0, 0);
        tick();
        chk("add_valid", wb1_valid, 1);
        chk("add_rd", wb1_rd, 5);
        chk("add_result", wb1_result, 32'h10);
        chk("add_noreq", req_cnt, 0);

        set_instr(4'h8, 3'd0, 32'h1003, 0, 2'd1, 1, 5'd6, 32'h104, 0, 0);
        #1 chk("lb_addr", dmem_addr, 32'h1000);
        mem_instr(2, 1, 32'h8012_3456, 0, 1);
        chk("lb_req_cycles", req_cnt, 3);
        chk("lb_stall_cycles", stall_cnt, 4);
        chk("lb_result", wb1_result, 32'hFFFF_FF80);

        set_instr(4'h2, 3'd0, 32'h2002, 32'hABCD, 2'd0, 0, 5'd0, 32'h108, 0, 0);
        #1;
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_we", dmem_we, 1);
        mem_instr(0, 0, 0, 0, 1);
        chk("sh_regwrite", wb1_regwrite, 0);

        set_instr(4'hA, 3'd0, 32'h3001, 0, 2'd1, 1, 5'd7, 32'h10C, 0, 0);
        #1 chk("lwmis_stall", me1_stall, 0);
        tick();
        chk("lwmis_exc", wb1_exc, 1);
        chk("lwmis_cause", wb1_cause, 1);
        chk("lwmis_regwrite", wb1_regwrite, 0);
        chk("lwmis_noreq", req_cnt, 0);

        set_instr(4'h0, 3'd1, 0, 0, 2'd0, 0, 5'd0, 32'h110, 32'h400, 1);
        #1 chk("beq_redirect", me1_redirect, 1);
        chk("beq_target", me1_target, 32'h400);
        tick();
        set_instr(4'h0, 3'd2, 0, 0, 2'd0, 0, 5'd0, 32'h114, 32'h500, 1);
        #1 chk("bne_noredirect", me1_redirect, 0);
        tick();

        set_instr(4'hD, 3'd0, 32'h7002, 0, 2'd1, 1, 5'd8, 32'h118, 0, 0);
        mem_instr(1, 0, 32'h1234_5678, 1, 1);
        chk("err_cause", wb1_cause, 2);
        chk("err_regwrite", wb1_regwrite, 0);

        set_instr(4'h9, 3'd0, 32'h8002, 0, 2'd1, 1, 5'd9, 32'h11C, 0, 0);
        mem_instr(0, 2, 32'h8001_1234, 0, 1);
        chk("lh_result", wb1_result, 32'hFFFF_8001);

        set_instr(4'hC, 3'd0, 32'h9001, 0, 2'd1, 1, 5'd10, 32'h120, 0, 0);
        mem_instr(0, 0, 32'h0000_F000, 0, 1);
        chk("lbu_result", wb1_result, 32'hF0);

        set_instr(4'h1, 3'd0, 32'hA003, 32'h5A, 2'd0, 0, 5'd0, 32'h124, 0, 0);
        #1 chk("sb_be", dmem_be, 4'b1000);
        chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        mem_instr(0, 0, 0, 0, 1);

        set_instr(4'h0, 3'd3, 32'h0, 0, 2'd2, 1, 5'd1, 32'h100, 32'h800, 0);
        tick();
        chk("jal_result", wb1_result, 32'h104);
        set_instr(4'h0, 3'd4, 32'h1, 0, 2'd0, 0, 5'd0, 32'h128, 32'h900, 0);
        tick();
        set_instr(4'h0, 3'd5, 32'h1, 0, 2'd0, 0, 5'd0, 32'h12C, 32'hA00, 0);
        tick();

        set_instr(4'hA, 3'd0, 32'h5000, 0, 2'd1, 1, 5'd11, 32'h130, 0, 0);
        mem_instr(0, TMO + 1, 0, 0, 0);
        chk("tmo_stall_cycles", stall_cnt, 5);
        chk("tmo_exc", wb1_exc, 1);
        chk("tmo_cause", wb1_cause, 3);
        bubble();
        dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid = 0;
        chk("stray_rvalid", wb1_valid, 0);

        set_instr(4'hA, 3'd0, 32'h6000, 0, 2'd1, 1, 5'd12, 32'h134, 0, 0);
        dmem_gnt = 1;
        tick();
        dmem_gnt = 0;
        tick();
        RST = 0;
        #1;
        chk("rstmid_req", dmem_req, 0);
        chk("rstmid_stall", me1_stall, 0);
        tick();
        RST = 1;
        bubble();
        dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
        tick();
        dmem_rvalid = 0;
        chk("rstmid_wb1_valid", wb1_valid, 0);
        chk("rstmid_wb1_result", wb1_result, 0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
